// File: rtl/add_sub_serial.sv
// Digit-serial adder/subtractor with valid/ready handshakes, DIGIT bits per clock, LSB first.
// Define ADD_SUB_SAT_EN to saturate the result on signed overflow instead of wrapping.
module add_sub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int AW   = (NDIG > 1) ? (WIDTH - DIGIT) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [AW-1:0]    acc_reg, acc_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             carry_reg, carry_next;
   logic             a_msb_reg, a_msb_next;
   logic             b_msb_reg, b_msb_next;
   logic [WIDTH-1:0] s_reg, s_next;
   logic             c_out_reg, c_out_next;
   logic             ovf_reg, ovf_next;
   logic             zero_reg, zero_next;

   logic [DIGIT:0]   digit_sum;
   logic [WIDTH-1:0] acc_shift;
   logic [AW-1:0]    acc_upd;
   logic             raw_ovf;
   logic [WIDTH-1:0] final_s;

   assign digit_sum = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                    + {{DIGIT{1'b0}}, carry_reg};

   // Completed result once the current digit lands on top of the partial sum.
   generate
      if (NDIG > 1) begin : g_multi
         assign acc_shift = {digit_sum[DIGIT-1:0], acc_reg};
         assign acc_upd   = acc_shift[WIDTH-1:DIGIT];
      end else begin : g_single
         assign acc_shift = digit_sum[DIGIT-1:0];
         assign acc_upd   = 1'b0;
      end
   endgenerate

   assign raw_ovf = (a_msb_reg == b_msb_reg) && (acc_shift[WIDTH-1] != a_msb_reg);

`ifdef ADD_SUB_SAT_EN
   always_comb begin
      final_s = acc_shift;
      if (raw_ovf) begin
         final_s = {1'b1, {(WIDTH-1){1'b0}}};
         if (!a_msb_reg) final_s = ~final_s;
      end
   end
`else
   assign final_s = acc_shift;
`endif

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      a_msb_next = a_msb_reg;
      b_msb_next = b_msb_reg;
      s_next     = s_reg;
      c_out_next = c_out_reg;
      ovf_next   = ovf_reg;
      zero_next  = zero_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = sub ? ~b : b;
               carry_next = sub;
               a_msb_next = a[WIDTH-1];
               b_msb_next = sub ? ~b[WIDTH-1] : b[WIDTH-1];
               cnt_next   = '0;
               state_next = CALC;
            end
         end
         CALC: begin
            a_next     = a_reg >> DIGIT;
            b_next     = b_reg >> DIGIT;
            carry_next = digit_sum[DIGIT];
            acc_next   = acc_upd;
            cnt_next   = cnt_reg + CW'(1);
            if (cnt_reg == CW'(NDIG - 1)) begin
               state_next = DONE;
               s_next     = final_s;
               c_out_next = digit_sum[DIGIT];
               ovf_next   = raw_ovf;
               zero_next  = (final_s == '0);
            end
         end
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         a_msb_reg <= 1'b0;
         b_msb_reg <= 1'b0;
         s_reg     <= '0;
         c_out_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         zero_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         a_msb_reg <= a_msb_next;
         b_msb_reg <= b_msb_next;
         s_reg     <= s_next;
         c_out_reg <= c_out_next;
         ovf_reg   <= ovf_next;
         zero_reg  <= zero_next;
      end
   end

   assign in_ready  = (state_reg == IDLE) && !rst;
   assign out_valid = (state_reg == DONE);
   assign s         = s_reg;
   assign c_out     = c_out_reg;
   assign ovf       = ovf_reg;
   assign zero      = zero_reg;

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Parametrised, digit-serial signed/unsigned adder-subtractor with valid/ready handshakes on both sides. It computes `A ± B` `DIGIT` bits per clock, from LSB to MSB, and then holds the result until the consumer accepts it. Each result comes with carry/borrow, signed-overflow and zero flags. It is the sequential, width-generic successor to the fixed 4-bit combinational add/sub unit, and is used wherever wide operands must be handled in little area.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width in bits; must be ≥ 2.
- `DIGIT`, 4: bits processed per cycle; must divide `WIDTH`. `NDIG = WIDTH/DIGIT`.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: operands presented.
- `in_ready`, out, 1: unit can accept operands.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `sub`, in, 1: 0 selects `A+B`; 1 selects `A−B`.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts the result.
- `s`, out, `WIDTH`: result.
- `c_out`, out, 1: carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf`, out, 1: two's-complement signed overflow.
- `zero`, out, 1: `s` is all zeros.

## Operation
- FSM states: `IDLE`, `CALC`, `DONE`.
- `IDLE`:
  - `in_ready=1`.
  - On `in_valid & in_ready`, capture `a`, `b_eff = sub ? ~b : b`, `carry = sub`, and the sign bits `a[WIDTH-1]` and `b_eff[WIDTH-1]`.
  - Clear the digit counter and go to `CALC`.
- `CALC`:
  - Each cycle, add the low `DIGIT` bits of the A and `b_eff` shift registers plus `carry`.
  - Shift the sum digit into the result register from the top, and register the digit carry.
  - After `NDIG` digits, go to `DONE`.
- Result register update on entry to `DONE`:
  - `c_out` = final carry.
  - `ovf` = (`a_msb == beff_msb`) & (`s_msb != a_msb`).
  - `zero` = (final `s == 0`), computed after any saturation.
- `DONE`:
  - `out_valid=1`.
  - `s`, `c_out`, `ovf` and `zero` are stable until `out_valid & out_ready`, then the FSM returns to `IDLE`.
- `in_ready=0` in `CALC` and `DONE`. `in_valid` is ignored there and no operand is captured.
- `out_valid` is never asserted outside `DONE`.
- After the result handshake, `s` and the flags keep their last values until the next result is written.
- Arithmetic is modulo 2^`WIDTH`. There is no sign extension and no widened output; the carry is reported only on `c_out`.

## Timing
- Reset values, in the cycle after `rst` is sampled high:
  - State is `IDLE`.
  - `in_ready=1`, `out_valid=0`.
  - `s=0`, `c_out=0`, `ovf=0`, `zero=0`.
- While `rst=1`, `in_ready` is driven 0.
- Reset mid-operation, in `CALC` or `DONE`: the operation is abandoned and its result never appears.
- Latency: the accept edge is edge 0. `out_valid` is high after edge `NDIG`.
- Minimum initiation interval: `NDIG+2` cycles, because the `DONE` handshake edge returns the FSM to `IDLE` and the next accept happens on the following edge.
- `WIDTH == DIGIT` (`NDIG=1`): `CALC` lasts exactly one cycle.
- `out_ready` high before `DONE` has no effect.
- `in_valid` during the `DONE` handshake cycle is not captured, since `in_ready=0`.

## Configuration
- `ADD_SUB_SAT_EN` defined:
  - On signed overflow, `s` saturates to `0111…1` if `a_msb==0`, otherwise to `1000…0`.
  - `ovf` is still 1.
  - `c_out` is unchanged, i.e. it is the raw carry.
- Not defined: `s` wraps modulo 2^`WIDTH`, and `ovf` is reported only.

## Test plan
All cases use `WIDTH=8`, `DIGIT=4`.
- **Add, no overflow:** `a=0x02, b=0x03, sub=0`, accept on edge 0 → `out_valid` after edge 2; `s=0x05`, `c_out=0`, `ovf=0`, `zero=0`.
- **Subtract:**
  - `a=0x06, b=0x03, sub=1` → `s=0x03`, `c_out=1`, `ovf=0`.
  - `a=0x03, b=0x06, sub=1` → `s=0xFD`, `c_out=0`, `ovf=0`.
  - `a=0x05, b=0x05, sub=1` → `s=0x00`, `zero=1`, `c_out=1`.
- **Overflow:**
  - `0x7F+0x01` → `ovf=1`; `s=0x80` without the macro, `s=0x7F` with `ADD_SUB_SAT_EN`.
  - `0x80−0x01` → `ovf=1`; `s=0x7F` without the macro, `s=0x80` with it.
- **Backpressure:** hold `out_ready=0` for 3 cycles in `DONE` and pulse `in_valid` with new operands → `s` and flags held, `in_ready=0`, new operands not captured. Raise `out_ready` → back to `IDLE` next cycle and the next accept succeeds.
- **Reset mid-operation:** assert `rst` during `CALC` → next cycle `in_ready=1`, `out_valid=0`, all outputs 0, and no result is produced.
- **Back-to-back throughput:** `in_valid` and `out_ready` held high for 4 operand pairs → one result every 4 cycles, in order, with correct values.
